// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared definitions for the buffered UART transmit front-end.
//   DEPTH_BITS_DEF : default log2 FIFO depth
//   tx_state_e     : issue FSM state encoding
package uart_tx_fifo_pkg;

  localparam int DEPTH_BITS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock circular FIFO.
//   clk, rst (async active-low)
//   push, wdata   : enqueue; accepted when not full, or when full with a same-cycle pop
//   pop, rdata    : dequeue; rdata shows the head entry combinationally
//   full, empty, count : occupancy, decoded from the registered count
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int D = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is intentionally not reset.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queues bytes from a producer and feeds them one at a time to
// the UART transmitter, waiting for each transfer to finish before the next.
//   clk, rst (async active-low)
//   ena              : low holds the issue FSM in IDLE (pushes still accepted)
//   wr_data, wr_en   : enqueue strobe
//   full, empty, count : FIFO occupancy
//   overflow, clr_ovf  : sticky dropped-write flag and its clear (set wins)
//   tx_data, tx_start, tx_busy : transmitter handshake
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_BITS = DEPTH_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  tx_state_e  state;
  logic       pop;
  logic [7:0] head;
  logic       drop;

  // The only pop is the IDLE->START decision; tx_data is loaded on that edge
  // and therefore cannot move while a transfer is in flight.
  assign pop  = (state == IDLE) && ena && !empty && !tx_busy;
  assign drop = wr_en && full && !pop;

  sync_fifo #(.W(8), .AW(DEPTH_BITS)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else      overflow <= drop | (overflow & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_data  <= head;
          tx_start <= 1'b1;
          state    <= START;
        end
        START:     state <= WAIT_BUSY;
        // No timeout: a transmitter that never raises busy stalls issue here.
        WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // DEPTH documents the capacity; full/count are derived inside the FIFO.
  logic unused_depth;
  assign unused_depth = (DEPTH == 0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a byte scoreboard. Every accepted push
// queues its byte; every tx_start pulse pops and compares tx_data.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;

  // transmitter model: busy for busy_len cycles after each start
  logic busy_hold = 1'b0;
  logic model_en = 1'b1;
  int   busy_len = 20;
  int   bcnt = 0;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic prev_busy = 1'b0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .ena(ena), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_ovf(clr_ovf), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  assign tx_busy = busy_hold | (bcnt != 0);

  always @(posedge clk) begin
    if (!model_en)       bcnt <= 0;
    else if (tx_start)   bcnt <= busy_len;
    else if (bcnt != 0)  bcnt <= bcnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && starts < n; i++) tick();
    chk(tag, 32'(starts), 32'(n));
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    wr_en = 1'b1;
    wr_data = b;
    if (accepted) sb.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  // Every start must carry the next expected byte and be issued only after
  // the transmitter was seen idle.
  task automatic monitor();
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        starts++;
        chk("start_while_busy", 32'(prev_busy), 32'd0);
        if (sb.size() == 0) chk("unexpected_start", 32'(tx_data), 32'hFFFF);
        else begin
          exp = sb.pop_front();
          chk("tx_data_order", 32'(tx_data), 32'(exp));
        end
      end
      prev_busy = tx_busy;
    end
  endtask

  initial begin
    int s0;
    fork monitor(); join_none

    // reset state
    repeat (3) tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    rst = 1'b1;
    repeat (2) tick();

    // single byte latency
    s0 = starts;
    push(8'hA5, 1'b1);
    chk("lat_count1", 32'(count), 32'd1);
    tick();
    chk("lat_start", 32'(tx_start), 32'd1);
    chk("lat_data", 32'(tx_data), 32'hA5);
    chk("lat_count0", 32'(count), 32'd0);
    chk("lat_empty", 32'(empty), 32'd1);
    tick();
    chk("lat_start_pulse", 32'(tx_start), 32'd0);
    repeat (30) tick();

    // three bytes against a 20-cycle transmitter
    s0 = starts;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    wait_starts("three_starts", s0 + 3, 200);
    repeat (30) tick();
    chk("three_empty", 32'(empty), 32'd1);

    // fill to overflow with transmitter held busy
    busy_hold = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h10 + 8'(i), i < 16);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // push and pop in the same cycle while full
    s0 = starts;
    busy_hold = 1'b0;
    push(8'hEE, 1'b1);
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_start", 32'(tx_start), 32'd1);
    wait_starts("pp_drain", s0 + 17, 1500);
    repeat (30) tick();
    chk("pp_empty", 32'(empty), 32'd1);

    // enable gating
    s0 = starts;
    ena = 1'b0;
    push(8'hAA, 1'b1);
    push(8'hBB, 1'b1);
    repeat (30) tick();
    chk("ena_blocked", 32'(starts), 32'(s0));
    chk("ena_count", 32'(count), 32'd2);
    ena = 1'b1;
    wait_starts("ena_resume", s0 + 1, 20);
    repeat (5) tick();
    ena = 1'b0;
    repeat (60) tick();
    chk("ena_drop_starts", 32'(starts), 32'(s0 + 1));
    chk("ena_drop_count", 32'(count), 32'd1);
    ena = 1'b1;
    wait_starts("ena_final", s0 + 2, 20);
    repeat (30) tick();

    // reset while stuck in WAIT_BUSY with 4 bytes queued
    model_en = 1'b0;
    s0 = starts;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b1);
    wait_starts("rst_mid_start", s0 + 1, 20);
    repeat (3) tick();
    chk("rst_mid_queued", 32'(count), 32'd4);
    rst = 1'b0;
    #1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_start_low", 32'(tx_start), 32'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    model_en = 1'b1;
    repeat (20) tick();
    chk("rst_mid_no_start", 32'(starts), 32'(s0 + 1));
    push(8'h5A, 1'b1);
    tick();
    chk("rst_mid_new_start", 32'(tx_start), 32'd1);
    chk("rst_mid_new_data", 32'(tx_data), 32'h5A);
    repeat (30) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
